// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encodings, NOP encoding, default MDU latency, load-use helper.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MDUWAIT = 2'd2
  } state_e;

  // Instruction word used when a pipeline register is cleared (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default cycles from an accepted mult/div until HI/LO are valid.
  localparam int DEFAULT_MDU_LAT = 32;

  // A load in EXE feeds a source of the ID instruction; $0 never creates a hazard.
  function automatic logic is_load_use(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_countdown.sv
// mdu_countdown: tracks the remaining latency of the multi-cycle MDU.
// The cycle in which the op is accepted is the first latency cycle, so the
// counter is loaded with MDU_LAT-1 and reaches zero exactly when HI/LO are valid.
module mdu_countdown #(
  parameter int CNT_W   = 6,
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic busy_o,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load on accept, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register; reset discards any in-flight MDU operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);
  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush control for load-use, taken-branch and
// multi-cycle MDU hazards in the 5-stage pipeline.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating perf counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = DEFAULT_MDU_LAT,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_Rs,
  input  logic [4:0]  id_Rt,
  input  logic        id_UsesRt,
  input  logic        id_MduStart,
  input  logic        id_MduRead,
  input  logic        exe_MemRead,
  input  logic [4:0]  exe_RegisterRd,
  input  logic        exe_BranchTaken,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        mdu_busy,
  output logic        mdu_go
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_cnt
`endif
);

  state_e state_q;
  state_e state_d;
  logic   sync_q;
  logic   ready_q;
  logic   cnt_busy;
  logic   cnt_last;
  logic   load_use;
  logic   mdu_block;

  mdu_countdown #(
    .CNT_W  (CNT_W),
    .MDU_LAT(MDU_LAT)
  ) u_mdu_countdown (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(mdu_go),
    .busy_o(cnt_busy),
    .last_o(cnt_last)
  );

  assign load_use  = is_load_use(exe_MemRead, exe_RegisterRd, id_Rs, id_Rt, id_UsesRt);
  assign mdu_block = (id_MduRead | id_MduStart) & cnt_busy;
  assign mdu_busy  = cnt_busy;

  // Keep all controls quiet during reset and for one full cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= 1'b1;
      ready_q <= sync_q;
    end
  end

  // Hazard priority: MDU wait > branch > load-use > MDU block > MDU accept.
  // LDSTALL lasts one cycle and simply re-applies the RUN rules.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mdu_go      = 1'b0;
    state_d     = ST_RUN;
    if (ready_q) begin
      if ((state_q == ST_MDUWAIT) && cnt_busy) begin
        // EXE holds a bubble here, so a branch indication cannot be genuine.
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = cnt_last ? ST_RUN : ST_MDUWAIT;
      end else if (exe_BranchTaken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = ST_LDSTALL;
      end else if (mdu_block) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = ST_MDUWAIT;
      end else if (id_MduStart) begin
        mdu_go = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating observation counters; they never feed back into control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a stimulus process drives each cycle
// and pushes the reference model's expected controls; a monitor pops and compares.
module tb_hazard_stall_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_Rs, id_Rt, exe_RegisterRd;
  logic       id_UsesRt, id_MduStart, id_MduRead, exe_MemRead, exe_BranchTaken;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, mdu_go;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_Rs          (id_Rs),
    .id_Rt          (id_Rt),
    .id_UsesRt      (id_UsesRt),
    .id_MduStart    (id_MduStart),
    .id_MduRead     (id_MduRead),
    .exe_MemRead    (exe_MemRead),
    .exe_RegisterRd (exe_RegisterRd),
    .exe_BranchTaken(exe_BranchTaken),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .mdu_busy       (mdu_busy),
    .mdu_go         (mdu_go)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cnt   (perf_flush_cnt)
`endif
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [5:0]  ctl;      // {pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, mdu_go}
    logic [31:0] stalls;
    logic [15:0] flushes;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: time-based view of the pipeline rules.
  int          m_cyc      = 0;   // current cycle index
  int          m_done_at  = 0;   // cycle at which HI/LO become valid
  int          m_rdy      = 0;   // clock edges seen with reset released
  bit          m_waiting  = 0;   // previous cycle was stalled waiting on the MDU
  logic [31:0] m_stalls   = 0;
  logic [15:0] m_flushes  = 0;
  bit          p_go = 0, p_mwait = 0, p_stall = 0, p_flush = 0;

  task automatic step(input logic rstn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic uses, input logic start,
                      input logic hilo, input logic memrd, input logic br, input string tag);
    exp_t e;
    bit   busy, lu, st3, fl, go, mw;
    @(posedge clk);
    #1;
    // Account for the clock edge just taken (reset level was the previous drive).
    if (rst_n) begin
      if (m_rdy < 2) m_rdy++;
      if (p_go) m_done_at = m_cyc + MDU_LAT;
      m_waiting = p_mwait;
      if (p_stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (p_flush && m_flushes != 16'hFFFF) m_flushes++;
    end
    m_cyc++;
    rst_n = rstn; id_Rs = rs; id_Rt = rt; exe_RegisterRd = rd; id_UsesRt = uses;
    id_MduStart = start; id_MduRead = hilo; exe_MemRead = memrd; exe_BranchTaken = br;
    if (!rstn) begin
      m_rdy = 0; m_done_at = 0; m_waiting = 0; m_stalls = 0; m_flushes = 0;
    end
    busy = (m_cyc < m_done_at);
    st3 = 0; fl = 0; go = 0; mw = 0;
    if (rstn && m_rdy == 2) begin
      lu = memrd && (rd != 0) && ((rd == rs) || (uses && rd == rt));
      if (m_waiting && busy)            begin st3 = 1; mw = 1; end
      else if (br)                      fl = 1;
      else if (lu)                      st3 = 1;
      else if ((start || hilo) && busy) begin st3 = 1; mw = 1; end
      else if (start)                   go = 1;
    end
    e.tag = tag; e.cyc = m_cyc;
    e.ctl = {st3, st3, fl, st3 | fl, busy, go};
    e.stalls = m_stalls; e.flushes = m_flushes;
    sb.push_back(e);
    p_go = go; p_mwait = mw; p_stall = st3; p_flush = fl;
  endtask

  task automatic idle(input logic rstn, input string tag);
    step(rstn, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: combinational controls are presented every cycle; sample mid-cycle.
  initial begin
    exp_t       e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy, mdu_go};
        n_checks++;
        if (got === e.ctl) n_pass++;
        else $display("FAIL %s cyc=%0d ctl{pc,ifst,flush,bub,busy,go} got=%b exp=%b",
                      e.tag, e.cyc, got, e.ctl);
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (perf_stall_cycles === e.stalls && perf_flush_cnt === e.flushes) n_pass++;
        else $display("FAIL %s_perf cyc=%0d got stalls=%0d flushes=%0d exp stalls=%0d flushes=%0d",
                      e.tag, e.cyc, perf_stall_cycles, perf_flush_cnt, e.stalls, e.flushes);
`endif
      end
    end
  end

  initial begin
    int rst_hold = 0;
    rst_n = 1'b0; id_Rs = '0; id_Rt = '0; exe_RegisterRd = '0; id_UsesRt = 1'b0;
    id_MduStart = 1'b0; id_MduRead = 1'b0; exe_MemRead = 1'b0; exe_BranchTaken = 1'b0;

    idle(1'b0, "reset");
    idle(1'b0, "reset");
    // Reset release with hazard-looking inputs: must stay quiet for the ramp.
    step(1'b1, 5'd1, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "post_reset");
    step(1'b1, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "post_reset");
    idle(1'b1, "idle");

    // lw $1 in EXE, add $2,$1,$3 in ID: one stall, then issue with EXE bubble.
    step(1'b1, 5'd1, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "load_use");
    step(1'b1, 5'd1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "load_use_issue");
    step(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "load_r0");
    step(1'b1, 5'd4, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "store_form");
    step(1'b1, 5'd1, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "load_use_branch");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "branch_kills_mult");

    // mult accepted, then mflo waits until HI/LO are valid.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mult_go");
    for (int i = 0; i < MDU_LAT; i++)
      step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mflo_wait");
    idle(1'b1, "idle");

    // mult, then reset while the countdown is mid-flight.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mult_go2");
    idle(1'b1, "mdu_busy");
    idle(1'b1, "mdu_busy");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset_mid_mdu");
    idle(1'b0, "reset_mid_mdu");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_reset2");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "post_reset2");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "mflo_after_reset");

    // Randomized traffic with small register numbers so hazards collide often.
    for (int i = 0; i < 1500; i++) begin
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 199) == 0) rst_hold = $urandom_range(1, 3);
      step(rst_hold == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 10, "random");
    end

    // Let the monitor drain; leftover entries mean it never saw the DUT cycle.
    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain got=%0d pending exp=0 pending", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
